mix_columns_seq: RTL and testbench

MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

---
 rtl/mix_columns_seq.sv | 110 +++++++++++
 tb/tb_mix_columns_seq.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequences a full masked state through a shared
// single-column mixer, one column per MIX cycle, with a randomness
// handshake before mixing.
// Optional feature macro: CLM_FRESH_RAND_EN. When it is defined, fresh
// randomness is fetched before every column. When it is undefined, one
// randomness word is fetched and then reused for all four columns.
module mix_columns_seq #(
  parameter  int d  = 2,
  localparam int PW = 8 * (d + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [3:0][3:0][PW-1:0] in,
  output logic                   busy,
  output logic                   done,
  output logic [3:0][3:0][PW-1:0] out,
  output logic                   rnd_req,
  input  logic                   rnd_valid,
  input  logic [0:15][PW-1:0]    random_in,
  output logic [3:0][PW-1:0]     col_in,
  output logic [0:15][PW-1:0]    col_rand,
  input  logic [3:0][PW-1:0]     col_out
);

  typedef enum logic [1:0] {IDLE, RAND, MIX, DONE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              col_q, col_d;
  logic [3:0][3:0][PW-1:0] in_reg_q, in_reg_d;
  logic [0:15][PW-1:0]     rand_reg_q, rand_reg_d;
  logic [3:0][3:0][PW-1:0] out_q, out_d;

  // State register and datapath flops; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      in_reg_q   <= '0;
      rand_reg_q <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      in_reg_q   <= in_reg_d;
      rand_reg_q <= rand_reg_d;
      out_q      <= out_d;
    end
  end

  // Next-state and datapath update: capture, fetch randomness, write columns
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    in_reg_d   = in_reg_q;
    rand_reg_d = rand_reg_q;
    out_d      = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          in_reg_d = in;
          col_d    = 2'd0;
          state_d  = RAND;
        end
      end
      RAND: begin
        if (rnd_valid) begin
          rand_reg_d = random_in;
          state_d    = MIX;
        end
      end
      MIX: begin
        for (int r = 0; r < 4; r++) begin
          out_d[r][col_q] = col_out[r];
        end
        if (col_q == 2'd3) begin
          state_d = DONE;
        end else begin
          col_d = col_q + 2'd1;
`ifdef CLM_FRESH_RAND_EN
          state_d = RAND;
`else
          state_d = MIX;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: status flags and the column/randomness presented to the mixer
  always_comb begin
    busy     = (state_q != IDLE);
    done     = (state_q == DONE);
    rnd_req  = (state_q == RAND);
    col_rand = rand_reg_q;
    col_in   = '0;
    for (int r = 0; r < 4; r++) begin
      col_in[r] = in_reg_q[r][col_q];
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: randomized scoreboard bench for mix_columns_seq.
// Provides a behavioural column mixer and randomness source, and predicts
// the mixed state from whole-state arithmetic.
// Honours CLM_FRESH_RAND_EN the same way the design does.
module tb_mix_columns_seq;

  localparam int D  = 2;
  localparam int PW = 8 * (D + 1);
  localparam int SW = 16 * PW;
`ifdef CLM_FRESH_RAND_EN
  localparam int XFERS   = 4;
  localparam int LAT     = 8;
  localparam int ABORT_K = 6;
`else
  localparam int XFERS   = 1;
  localparam int LAT     = 5;
  localparam int ABORT_K = 4;
`endif

  typedef logic [PW-1:0]           poly_t;
  typedef logic [3:0][PW-1:0]      col_t;
  typedef logic [3:0][3:0][PW-1:0] state_t;
  typedef logic [0:15][PW-1:0]     rand_t;
  typedef struct {
    state_t exp_out;
    bit     check_lat;
    int     start_cyc;
  } exp_t;

  logic   clk, rst_n, start, busy, done, rnd_req, rnd_valid;
  state_t in_state, out_state;
  rand_t  random_in, col_rand;
  col_t   col_in, col_out;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     xfer_count = 0;
  bit     xfer_pending = 0;
  bit     rnd_enable = 1;
  exp_t   exp_q[$];
  rand_t  rng_q[$];
  state_t last_exp = '0;

  mix_columns_seq #(.d(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in_state),
    .busy(busy), .done(done), .out(out_state),
    .rnd_req(rnd_req), .rnd_valid(rnd_valid), .random_in(random_in),
    .col_in(col_in), .col_rand(col_rand), .col_out(col_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Share-wise AES MixColumns followed by a randomness-dependent refresh
  function automatic col_t mixColumn(input col_t c, input rand_t rv);
    col_t       res;
    logic [7:0] a [4];
    res = '0;
    for (int s = 0; s <= D; s++) begin
      for (int i = 0; i < 4; i++) a[i] = c[i][s*8 +: 8];
      for (int i = 0; i < 4; i++)
        res[i][s*8 +: 8] = xtime(a[i]) ^ xtime(a[(i+1)%4]) ^ a[(i+1)%4]
                         ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    for (int i = 0; i < 4; i++) res[i] = res[i] ^ rv[i] ^ rv[i+8];
    return res;
  endfunction

  // Whole-state reference: each column mixed with the randomness it should see
  function automatic state_t refMix(input state_t s, input rand_t rv [4]);
    state_t res;
    col_t   c, m;
    res = '0;
    for (int cc = 0; cc < 4; cc++) begin
      for (int r = 0; r < 4; r++) c[r] = s[r][cc];
      m = mixColumn(c, rv[(XFERS == 4) ? cc : 0]);
      for (int r = 0; r < 4; r++) res[r][cc] = m[r];
    end
    return res;
  endfunction

  function automatic rand_t randVec();
    rand_t v;
    for (int i = 0; i < 16; i++) v[i] = poly_t'($urandom);
    return v;
  endfunction

  // Masked encoding of a byte value: share 0 absorbs the XOR of the masks
  function automatic poly_t encode(input logic [7:0] v);
    poly_t      p;
    logic [7:0] acc, m;
    acc = v;
    p = '0;
    for (int s = 1; s <= D; s++) begin
      m = 8'($urandom);
      p[s*8 +: 8] = m;
      acc = acc ^ m;
    end
    p[7:0] = acc;
    return p;
  endfunction

  function automatic state_t randState();
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = encode(8'($urandom));
    return s;
  endfunction

  function automatic bit expReq(input int k);
`ifdef CLM_FRESH_RAND_EN
    return (k == 1 || k == 3 || k == 5 || k == 7);
`else
    return (k == 1);
`endif
  endfunction

  // Behavioural shared mixer
  always_comb col_out = mixColumn(col_in, col_rand);

  // Randomness source: presents the queued word, pops it after a transfer
  always @(negedge clk) begin
    if (!rst_n) begin
      xfer_pending = 0;
    end else begin
      if (xfer_pending) begin
        xfer_count++;
        if (rng_q.size() > 0) void'(rng_q.pop_front());
      end
      random_in = (rng_q.size() > 0) ? rng_q[0] : randVec();
      rnd_valid = rnd_enable;
      xfer_pending = rnd_req && rnd_valid;
    end
  end

  task automatic checkOutput(input string name, input logic [SW-1:0] actual,
                             input logic [SW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest prediction
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1, expected no pending operation");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("out", out_state, e.exp_out);
        if (e.check_lat)
          checkOutput("done_cycle", SW'(cyc), SW'(e.start_cyc + LAT));
        checkOutput("xfer_count", SW'(xfer_count), SW'(XFERS));
      end
    end
  end

  // Issue one operation: queue its randomness and prediction, raise start
  task automatic applyStimulus(input state_t s, input bit check_lat,
                               output state_t exp_out);
    rand_t rv [4];
    exp_t  e;
    for (int i = 0; i < 4; i++) rv[i] = randVec();
    for (int i = 0; i < XFERS; i++) rng_q.push_back(rv[i]);
    e.exp_out   = refMix(s, rv);
    e.check_lat = check_lat;
    e.start_cyc = cyc + 1;
    exp_q.push_back(e);
    exp_out    = e.exp_out;
    xfer_count = 0;
    in_state   = s;
    start      = 1;
  endtask

  // Full operation with per-cycle status checks and optional stray starts
  task automatic runOp(input state_t s, input int pulse_a, input int pulse_b);
    state_t e_out;
    int     k;
    bit     seen;
    applyStimulus(s, 1'b1, e_out);
    k = 0;
    seen = 0;
    while (!seen && k < LAT + 10) begin
      @(negedge clk); #1;
      k++;
      start = (k == pulse_a || k == pulse_b);
      checkOutput("busy", SW'(busy), SW'(1'b1));
      checkOutput("rnd_req", SW'(rnd_req), SW'(expReq(k)));
      if (done) seen = 1;
    end
    checkOutput("done_k", SW'(k), SW'(LAT + 1));
    @(negedge clk); #1;
    start = 0;
    checkOutput("idle_busy", SW'(busy), SW'(1'b0));
    checkOutput("held_out", out_state, e_out);
    @(negedge clk); #1;
    checkOutput("no_restart", SW'(busy), SW'(1'b0));
    last_exp = e_out;
  endtask

  initial begin
    state_t s, e_out;
    int     k, rise_cyc;
    bit     seen;

    rst_n = 0; start = 0; rnd_enable = 1; rnd_valid = 0;
    in_state = '0; random_in = '0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", SW'(busy), SW'(1'b0));
    checkOutput("reset_done", SW'(done), SW'(1'b0));
    checkOutput("reset_rnd_req", SW'(rnd_req), SW'(1'b0));
    checkOutput("reset_out", out_state, '0);
    rst_n = 1;
    @(negedge clk); #1;

    // Directed ramp pattern in[r][c] = r*4+c
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = encode(8'(r * 4 + c));
    runOp(s, 0, 0);

    // Back-to-back random operations
    for (int i = 0; i < 6; i++) runOp(randState(), 0, 0);

    // Randomness stalled for 20 cycles
    $display("[TB] stall test");
    rnd_enable = 0;
    applyStimulus(randState(), 1'b0, e_out);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      start = 0;
      checkOutput("stall_busy", SW'(busy), SW'(1'b1));
      checkOutput("stall_done", SW'(done), SW'(1'b0));
      checkOutput("stall_rnd_req", SW'(rnd_req), SW'(1'b1));
      checkOutput("stall_out", out_state, last_exp);
    end
    rnd_enable = 1;
    k = 0;
    while (!rnd_valid && k < 5) begin
      @(negedge clk); #1;
      k++;
    end
    rise_cyc = cyc;
    seen = 0;
    k = 0;
    while (!seen && k < LAT + 10) begin
      @(negedge clk); #1;
      k++;
      if (done) seen = 1;
    end
    checkOutput("stall_resume_cycle", SW'(cyc), SW'(rise_cyc + LAT));
    last_exp = e_out;
    @(negedge clk); #1;

    // Stray start pulses in cycle 3 and in the done cycle
    $display("[TB] ignored start test");
    runOp(randState(), 3, LAT + 1);

    // Reset while mixing column 2
    $display("[TB] abort test");
    applyStimulus(randState(), 1'b1, e_out);
    k = 0;
    while (k < ABORT_K) begin
      @(negedge clk); #1;
      k++;
      start = 0;
    end
    rst_n = 0;
    #1;
    checkOutput("abort_busy", SW'(busy), SW'(1'b0));
    checkOutput("abort_done", SW'(done), SW'(1'b0));
    checkOutput("abort_rnd_req", SW'(rnd_req), SW'(1'b0));
    checkOutput("abort_out", out_state, '0);
    exp_q.delete();
    rng_q.delete();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1;
    last_exp = '0;
    @(negedge clk); #1;
    runOp(randState(), 0, 0);

    repeat (3) @(negedge clk);
    #1;
    checkOutput("pending_predictions", SW'(exp_q.size()), SW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no end of test, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
